// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word and the memory request sequencer states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DREQ   = 2'd1,
        HALTED = 2'd2
    } mru_state_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: a valid bit plus the linked 30-bit word address.
module link_reg (
    input  logic        CLK,
    input  logic        RST,
    input  logic        set,
    input  logic        clr,
    input  logic [29:0] set_addr,
    input  logic [29:0] cmp_addr,
    output logic        match
);

    logic        valid;
    logic [29:0] link_addr;

    // set wins over clr so an LL completing always establishes a fresh link
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid     <= 1'b0;
            link_addr <= '0;
        end else if (set) begin
            valid     <= 1'b1;
            link_addr <= set_addr;
        end else if (clr) begin
            valid     <= 1'b0;
        end
    end

    assign match = valid && (link_addr == cmp_addr);

endmodule

// File: rtl/mem_request_unit.sv
// Data-memory request sequencer: holds dmem requests until dhit, stalls the PC,
// and owns the LL/SC link and sticky halt.
//
// state  | meaning
// IDLE   | fetching; 1-cycle ops complete here, memory ops launch a request
// DREQ   | request held on the dmem port until dhit
// HALTED | absorbing until reset; no fetch, no requests
module mem_request_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              ll,
    input  logic              sc,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] store_data,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              pc_en,
    output logic [WORD_W-1:0] sc_result,
    output logic              halt
);

    mru_state_t        state;
    logic              is_sc_q;
    logic              is_ll_q;
    logic              link_set;
    logic              link_clr;
    logic              link_match;
    logic              sc_bit;
    logic              mem_op;
    logic              sc_fail;
    logic [WORD_W-3:0] cmp_addr;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];

    assign mem_op  = dREN_in | dWEN_in;
    assign sc_fail = dWEN_in & sc & ~link_match;

    // IDLE checks the incoming SC address; DREQ checks the store in flight
    assign cmp_addr = (state == DREQ) ? dmemaddr[WORD_W-1:2] : addr[WORD_W-1:2];

    link_reg u_link_reg (
        .CLK      (CLK),
        .RST      (RST),
        .set      (link_set),
        .clr      (link_clr),
        .set_addr (dmemaddr[WORD_W-1:2]),
        .cmp_addr (cmp_addr),
        .match    (link_match)
    );

    always_comb begin
        pc_en    = 1'b0;
        sc_bit   = 1'b0;
        link_set = 1'b0;
        link_clr = 1'b0;
        case (state)
            IDLE: begin
                if (ihit && !halt_in)
                    pc_en = !mem_op || sc_fail;
            end
            DREQ: begin
                if (dhit) begin
                    pc_en  = 1'b1;
                    sc_bit = is_sc_q;
                    if (is_sc_q)
                        link_clr = 1'b1;
                    else if (is_ll_q)
                        link_set = 1'b1;
                    else if (dmemWEN && link_match)
                        link_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign imemREN   = (state == IDLE);
    assign sc_result = {{(WORD_W-1){1'b0}}, sc_bit};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
            halt      <= 1'b0;
            is_sc_q   <= 1'b0;
            is_ll_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ihit) begin
                        if (halt_in) begin
                            state <= HALTED;
                            halt  <= 1'b1;
                        end else if (mem_op && !sc_fail) begin
                            state     <= DREQ;
                            dmemaddr  <= {addr[WORD_W-1:2], 2'b00};
                            dmemstore <= store_data;
                            dmemWEN   <= dWEN_in;
                            dmemREN   <= !dWEN_in;
                            is_sc_q   <= dWEN_in & sc;
                            is_ll_q   <= !dWEN_in & ll;
                        end
                    end
                end
                DREQ: begin
                    if (dhit) begin
                        state   <= IDLE;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        is_sc_q <= 1'b0;
                        is_ll_q <= 1'b0;
                    end
                end
                HALTED: begin
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: loads, stores, LL/SC linking, reset and halt.
module tb_mem_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dREN_in, dWEN_in, ll, sc, halt_in;
    logic [31:0] addr, store_data;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
    logic [31:0] dmemaddr, dmemstore, sc_result;

    int          n_cmp  = 0;
    int          n_fail = 0;

    int          ren_c, wen_c, pc_c;
    logic [31:0] sc_v, addr_v, store_v;

    mem_request_unit #(.WORD_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .dREN_in    (dREN_in),
        .dWEN_in    (dWEN_in),
        .ll         (ll),
        .sc         (sc),
        .halt_in    (halt_in),
        .addr       (addr),
        .store_data (store_data),
        .imemREN    (imemREN),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .pc_en      (pc_en),
        .sc_result  (sc_result),
        .halt       (halt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit       = 1'b0;
        dhit       = 1'b0;
        dREN_in    = 1'b0;
        dWEN_in    = 1'b0;
        ll         = 1'b0;
        sc         = 1'b0;
        halt_in    = 1'b0;
        addr       = '0;
        store_data = '0;
    endtask

    // Issue one instruction, answer dhit after wait_n held cycles, record what the port did.
    task automatic run_op(input logic ren, input logic wen, input logic ll_i, input logic sc_i,
                          input logic [31:0] a, input logic [31:0] d, input int wait_n);
        ren_c = 0; wen_c = 0; pc_c = 0;
        sc_v = '0; addr_v = '0; store_v = '0;
        ihit = 1'b1; dREN_in = ren; dWEN_in = wen; ll = ll_i; sc = sc_i;
        addr = a; store_data = d;
        #1;
        if (pc_en) begin pc_c++; sc_v = sc_result; end
        tick();
        idle_inputs();
        for (int k = 0; k <= wait_n; k++) begin
            dhit = (k == wait_n);
            #1;
            if (dmemREN) ren_c++;
            if (dmemWEN) wen_c++;
            if (k == 0) begin addr_v = dmemaddr; store_v = dmemstore; end
            if (pc_en) begin pc_c++; sc_v = sc_result; end
            tick();
        end
        dhit = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL reset_dmemREN got %b want 0", dmemREN); end
        n_cmp++; if (dmemWEN !== 1'b0) begin n_fail++; $display("FAIL reset_dmemWEN got %b want 0", dmemWEN); end
        n_cmp++; if (dmemaddr !== 32'h0) begin n_fail++; $display("FAIL reset_dmemaddr got %h want 0", dmemaddr); end
        n_cmp++; if (dmemstore !== 32'h0) begin n_fail++; $display("FAIL reset_dmemstore got %h want 0", dmemstore); end
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", halt); end
        n_cmp++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL reset_imemREN got %b want 1", imemREN); end
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got %b want 0", pc_en); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        ihit = 1'b1;
        #1;
        n_cmp++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL nonmem_pc_en got %b want 1", pc_en); end
        n_cmp++; if (sc_result !== 32'h0) begin n_fail++; $display("FAIL nonmem_sc_result got %h want 0", sc_result); end
        ihit = 1'b0;
        dhit = 1'b1;
        #1;
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL no_ihit_pc_en got %b want 0", pc_en); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL idle_dhit_ignored got %b want 0", dmemREN); end
    endtask

    task automatic test_lw();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 2);
        n_cmp++; if (ren_c !== 3) begin n_fail++; $display("FAIL lw_ren_cycles got %0d want 3", ren_c); end
        n_cmp++; if (wen_c !== 0) begin n_fail++; $display("FAIL lw_wen_cycles got %0d want 0", wen_c); end
        n_cmp++; if (addr_v !== 32'h104) begin n_fail++; $display("FAIL lw_dmemaddr got %h want 104", addr_v); end
        n_cmp++; if (pc_c !== 1) begin n_fail++; $display("FAIL lw_pc_en_pulses got %0d want 1", pc_c); end
        n_cmp++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL lw_ren_dropped got %b want 0", dmemREN); end
        n_cmp++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL lw_imemREN_after got %b want 1", imemREN); end
    endtask

    task automatic test_sw();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0203, 32'hDEAD_BEEF, 2);
        n_cmp++; if (addr_v !== 32'h200) begin n_fail++; $display("FAIL sw_dmemaddr got %h want 200", addr_v); end
        n_cmp++; if (store_v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_dmemstore got %h want deadbeef", store_v); end
        n_cmp++; if (wen_c !== 3) begin n_fail++; $display("FAIL sw_wen_cycles got %0d want 3", wen_c); end
        n_cmp++; if (ren_c !== 0) begin n_fail++; $display("FAIL sw_ren_cycles got %0d want 0", ren_c); end
        n_cmp++; if (pc_c !== 1) begin n_fail++; $display("FAIL sw_pc_en_pulses got %0d want 1", pc_c); end
        // both enables high: write wins
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0055, 0);
        n_cmp++; if (wen_c !== 1 || ren_c !== 0) begin n_fail++; $display("FAIL both_en_write_wins got wen=%0d ren=%0d want wen=1 ren=0", wen_c, ren_c); end
    endtask

    task automatic test_llsc();
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h1, 0);
        n_cmp++; if (wen_c !== 0 || pc_c !== 1 || sc_v !== 32'h0) begin n_fail++; $display("FAIL sc_no_link got wen=%0d pc=%0d sc=%h want 0 1 0", wen_c, pc_c, sc_v); end
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
        n_cmp++; if (ren_c !== 1) begin n_fail++; $display("FAIL ll_ren_cycles got %0d want 1", ren_c); end
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_00AA, 1);
        n_cmp++; if (wen_c !== 2) begin n_fail++; $display("FAIL sc_ok_wen_cycles got %0d want 2", wen_c); end
        n_cmp++; if (sc_v !== 32'h1) begin n_fail++; $display("FAIL sc_ok_result got %h want 1", sc_v); end
        n_cmp++; if (pc_c !== 1) begin n_fail++; $display("FAIL sc_ok_pc_en_pulses got %0d want 1", pc_c); end
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_00BB, 0);
        n_cmp++; if (wen_c !== 0) begin n_fail++; $display("FAIL sc_again_wen_cycles got %0d want 0", wen_c); end
        n_cmp++; if (sc_v !== 32'h0 || pc_c !== 1) begin n_fail++; $display("FAIL sc_again_result got sc=%h pc=%0d want 0 1", sc_v, pc_c); end
    endtask

    task automatic test_store_breaks_link();
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0077, 1);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0001, 0);
        n_cmp++; if (sc_v !== 32'h0 || wen_c !== 0) begin n_fail++; $display("FAIL sc_after_sw_same got sc=%h wen=%0d want 0 0", sc_v, wen_c); end
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 0);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0000_0077, 0);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0001, 0);
        n_cmp++; if (sc_v !== 32'h1 || wen_c !== 1) begin n_fail++; $display("FAIL sc_after_sw_other got sc=%h wen=%0d want 1 1", sc_v, wen_c); end
    endtask

    task automatic test_reset_mid_req();
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0);
        ihit = 1'b1; dWEN_in = 1'b1; addr = 32'h0000_0200; store_data = 32'h0000_1234;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (dmemWEN !== 1'b1) begin n_fail++; $display("FAIL midreq_wen_held got %b want 1", dmemWEN); end
        RST  = 1'b1;
        dhit = 1'b1;
        #1;
        n_cmp++; if (dmemWEN !== 1'b0) begin n_fail++; $display("FAIL midreq_wen_async_drop got %b want 0", dmemWEN); end
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL midreq_pc_en got %b want 0", pc_en); end
        n_cmp++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL midreq_idle got %b want 1", imemREN); end
        tick();
        RST  = 1'b0;
        dhit = 1'b0;
        tick();
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h1, 0);
        n_cmp++; if (sc_v !== 32'h0 || wen_c !== 0) begin n_fail++; $display("FAIL midreq_link_cleared got sc=%h wen=%0d want 0 0", sc_v, wen_c); end
    endtask

    task automatic test_halt();
        ihit = 1'b1; halt_in = 1'b1; dREN_in = 1'b1; addr = 32'h0000_0300;
        #1;
        n_cmp++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL halt_pc_en got %b want 0", pc_en); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b want 1", halt); end
        n_cmp++; if (dmemREN !== 1'b0) begin n_fail++; $display("FAIL halt_no_request got %b want 0", dmemREN); end
        for (int c = 0; c < 3; c++) begin
            ihit = 1'b1; dREN_in = 1'b1; dhit = 1'b1;
            #1;
            n_cmp++; if (imemREN !== 1'b0 || pc_en !== 1'b0 || halt !== 1'b1 || dmemREN !== 1'b0)
                begin n_fail++; $display("FAIL halt_sticky cyc %0d got imem=%b pc=%b halt=%b ren=%b want 0 0 1 0", c, imemREN, pc_en, halt, dmemREN); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_lw();
        test_sw();
        test_llsc();
        test_store_breaks_link();
        test_reset_mid_req();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
